spi_fl_read_seq: RTL

//  Upstream command sequencer for spi_master_fl. Accepts a block-read request
//  (start address, word count), issues one 32-bit read frame per word to the

---
 rtl/spi_fl_read_seq_pkg.sv | 34 +++
 rtl/spi_fl_read_seq_if.sv | 53 +++++
 rtl/spi_fl_rdfifo.sv | 64 ++++++
 rtl/spi_fl_read_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/spi_fl_read_seq_pkg.sv
// Shared definitions for the SPI flash block-read sequencer: default opcodes,
// frame encodings, FSM state type and address-arithmetic helpers.
package spi_fl_read_seq_pkg;

  localparam logic [7:0] CmdRd1Def   = 8'h0B;
  localparam logic [7:0] CmdRd4Def   = 8'h6B;
  localparam logic [7:0] CmdRd14bDef = 8'h0C;
  localparam logic [7:0] CmdRd44bDef = 8'h6C;
  localparam logic [3:0] DummyRdDef  = 4'd8;

  localparam logic [2:0] CommtypeRead   = 3'b100;
  localparam logic [1:0] SpimodeSingle  = 2'b00;
  localparam logic [1:0] SpimodeQuad    = 2'b10;
  localparam logic [6:0] NdataBits      = 7'd32;
  localparam logic [9:0] FrameStructDef = 10'h000;
  localparam logic [1:0] XipbitDef      = 2'b00;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  // Word-align the start address; 3-byte mode keeps only the low 24 bits.
  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic four_byte);
    if (four_byte) return {a[31:2], 2'b00};
    return {8'h00, a[23:2], 2'b00};
  endfunction

  // Advance by one word, wrapping within the active address width.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic four_byte);
    logic [23:0] lo;
    if (four_byte) return a + 32'd4;
    lo = a[23:0] + 24'd4;
    return {8'h00, lo};
  endfunction

endpackage

// File: rtl/spi_fl_read_seq_if.sv
// Bus bundle for spi_fl_read_seq: block-read request, read-data stream and the
// frame-control/handshake signals towards spi_master_fl.
//  slave  : view of the sequencer itself
//  master : view of the surrounding logic (requester, consumer, SPI master)
interface spi_fl_read_seq_if;
  import spi_fl_read_seq_pkg::*;

  // Request side
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_nwords;
  logic        req_quad;
  logic        req_4b;
  logic        done;
  logic        busy;
  // Read-data stream
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  // SPI master frame control
  logic [7:0]  command;
  logic [31:0] address;
  logic [2:0]  commtype;
  logic [6:0]  ndata_bits;
  logic [3:0]  dummy_cycles;
  logic [9:0]  frame_struct;
  logic [1:0]  xipbit_en;
  logic        manualframe_en;
  logic [1:0]  spimode;
  logic        fourbyteaddr_on;
  logic        validflag;
  logic        tready;
  logic        validflag_out;
  logic [31:0] data_out;

  modport slave (
    input  req_valid, req_addr, req_nwords, req_quad, req_4b, rd_ready,
           tready, validflag_out, data_out,
    output req_ready, done, busy, rd_valid, rd_data, command, address, commtype,
           ndata_bits, dummy_cycles, frame_struct, xipbit_en, manualframe_en,
           spimode, fourbyteaddr_on, validflag
  );

  modport master (
    output req_valid, req_addr, req_nwords, req_quad, req_4b, rd_ready,
           tready, validflag_out, data_out,
    input  req_ready, done, busy, rd_valid, rd_data, command, address, commtype,
           ndata_bits, dummy_cycles, frame_struct, xipbit_en, manualframe_en,
           spimode, fourbyteaddr_on, validflag
  );

endinterface

// File: rtl/spi_fl_rdfifo.sv
// First-word-fall-through synchronous FIFO for returned read words.
//  push_i/data_i : write side (push ignored when full unless a pop frees a slot)
//  full_o        : no free entry
//  pop_i         : consumer ready; pops only when an entry is present
//  valid_o/data_o: head entry visible whenever the FIFO is non-empty
module spi_fl_rdfifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];

  assign pop_ok  = pop_i & valid_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + PtrW'(1);
    if (pop_ok)  rd_d = rd_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/spi_fl_read_seq.sv
// Block-read command sequencer in front of spi_master_fl. Accepts a request
// (start address, word count, quad/4-byte flags), issues one 32-bit read frame
// per word via validflag/tready, and queues each returned word in a FWFT FIFO.
//  clk_i, rst_ni : clock, asynchronous active-low reset
//  bus           : request, read-data stream and master frame-control signals
module spi_fl_read_seq
  import spi_fl_read_seq_pkg::*;
#(
  parameter int unsigned FifoDepth = 4,
  parameter logic [7:0]  CmdRd1    = CmdRd1Def,
  parameter logic [7:0]  CmdRd4    = CmdRd4Def,
  parameter logic [7:0]  CmdRd14b  = CmdRd14bDef,
  parameter logic [7:0]  CmdRd44b  = CmdRd44bDef,
  parameter logic [3:0]  DummyRd   = DummyRdDef
) (
  input logic                clk_i,
  input logic                rst_ni,
  spi_fl_read_seq_if.slave   bus
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        quad_q, quad_d;
  logic        b4_q, b4_d;
  logic        vfo_q;
  logic        push;
  logic        fifo_full;
  logic        validflag;
  logic [7:0]  cmd_sel;

  always_comb begin
    cmd_sel = CmdRd1;
    unique case ({bus.req_4b, bus.req_quad})
      2'b00: cmd_sel = CmdRd1;
      2'b01: cmd_sel = CmdRd4;
      2'b10: cmd_sel = CmdRd14b;
      2'b11: cmd_sel = CmdRd44b;
      default: cmd_sel = CmdRd1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    quad_d    = quad_q;
    b4_d      = b4_q;
    push      = 1'b0;
    validflag = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = align_addr(bus.req_addr, bus.req_4b);
          cnt_d   = bus.req_nwords;
          cmd_d   = cmd_sel;
          quad_d  = bus.req_quad;
          b4_d    = bus.req_4b;
          state_d = (bus.req_nwords == 8'd0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        // Only one frame is ever outstanding, so one free slot is enough.
        if (bus.tready && !fifo_full) begin
          validflag = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (bus.validflag_out && !vfo_q) begin
          push    = 1'b1;
          addr_d  = next_addr(addr_q, b4_q);
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? StDone : StIssue;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      quad_q  <= 1'b0;
      b4_q    <= 1'b0;
      vfo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      quad_q  <= quad_d;
      b4_q    <= b4_d;
      vfo_q   <= bus.validflag_out;
    end
  end

  spi_fl_rdfifo #(
    .Depth (FifoDepth),
    .Width (32)
  ) u_rdfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (bus.data_out),
    .full_o  (fifo_full),
    .pop_i   (bus.rd_ready),
    .valid_o (bus.rd_valid),
    .data_o  (bus.rd_data)
  );

  assign bus.req_ready       = (state_q == StIdle);
  assign bus.busy            = (state_q != StIdle);
  assign bus.done            = (state_q == StDone);
  assign bus.validflag       = validflag;
  assign bus.command         = cmd_q;
  assign bus.address         = addr_q;
  assign bus.spimode         = quad_q ? SpimodeQuad : SpimodeSingle;
  assign bus.fourbyteaddr_on = b4_q;
  assign bus.commtype        = CommtypeRead;
  assign bus.ndata_bits      = NdataBits;
  assign bus.dummy_cycles    = DummyRd;
  assign bus.frame_struct    = FrameStructDef;
  assign bus.xipbit_en       = XipbitDef;
  assign bus.manualframe_en  = 1'b0;

endmodule
